// File: rtl/deco_7seg_pkg.sv
// Shared constants for the seven-segment decoder: segment bit positions,
// active-high glyph patterns and the 16-entry code-to-glyph lookup.
package deco_7seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Glyphs are bit i = segment i lit, g..a in bits 6:0.
    localparam logic [6:0] PAT_0     = 7'h3F;
    localparam logic [6:0] PAT_1     = 7'h06;
    localparam logic [6:0] PAT_2     = 7'h5B;
    localparam logic [6:0] PAT_3     = 7'h4F;
    localparam logic [6:0] PAT_4     = 7'h66;
    localparam logic [6:0] PAT_5     = 7'h6D;
    localparam logic [6:0] PAT_6     = 7'h7D;
    localparam logic [6:0] PAT_7     = 7'h07;
    localparam logic [6:0] PAT_8     = 7'h7F;
    localparam logic [6:0] PAT_9     = 7'h6F;
    localparam logic [6:0] PAT_A     = 7'h77;
    localparam logic [6:0] PAT_B     = 7'h7C;
    localparam logic [6:0] PAT_C     = 7'h39;
    localparam logic [6:0] PAT_D     = 7'h5E;
    localparam logic [6:0] PAT_E     = 7'h79;
    localparam logic [6:0] PAT_F     = 7'h71;
    localparam logic [6:0] PAT_DASH  = 7'h40;
    localparam logic [6:0] PAT_BLANK = 7'h00;

    function automatic logic [6:0] pattern_lookup(input logic [3:0] code);
        logic [6:0] pat;
        pat = PAT_BLANK;
        case (code)
            4'h0: pat = PAT_0;
            4'h1: pat = PAT_1;
            4'h2: pat = PAT_2;
            4'h3: pat = PAT_3;
            4'h4: pat = PAT_4;
            4'h5: pat = PAT_5;
            4'h6: pat = PAT_6;
            4'h7: pat = PAT_7;
            4'h8: pat = PAT_8;
            4'h9: pat = PAT_9;
            4'hA: pat = PAT_A;
            4'hB: pat = PAT_B;
            4'hC: pat = PAT_C;
            4'hD: pat = PAT_D;
            4'hE: pat = PAT_E;
            4'hF: pat = PAT_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/deco_7seg_lut.sv
// Combinational code-to-glyph decode; codes above 9 become a dash when
// hex display is disabled.
module deco_7seg_lut
    import deco_7seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       hex_en,
    output logic [6:0] pattern
);

    // NOTE: assigning a default at the top of always_comb guarantees every
    // path drives the output, so no latch is inferred.
    always_comb begin
        pattern = pattern_lookup(digit);
        if (!hex_en && (digit > 4'd9)) begin
            pattern = PAT_DASH;
        end
    end

endmodule

// File: rtl/deco_7seg.sv
// Registered seven-segment digit driver: glyph decode, lamp-test/blank
// priority, decimal-point overlay, polarity and one output register.
module deco_7seg
    import deco_7seg_pkg::*;
#(
    parameter int ACTIVE_LOW = 1,
    parameter int HEX_EN     = 1
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       en,
    input  logic [3:0] digit,
    input  logic       dp,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [7:0] seg
);

    localparam bit         INVERT   = (ACTIVE_LOW != 0);
    localparam logic [7:0] SEG_DARK = INVERT ? 8'hFF : 8'h00;

    logic [6:0] glyph;
    logic [7:0] pattern;
    logic [7:0] seg_next;

    deco_7seg_lut u_lut (
        .digit   (digit),
        .hex_en  (HEX_EN != 0),
        .pattern (glyph)
    );

    always_comb begin
        pattern = {dp, glyph};
        if (lamp_test) begin
            pattern = 8'hFF;
        end else if (blank) begin
            pattern = 8'h00;
        end
        seg_next = INVERT ? ~pattern : pattern;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            seg <= SEG_DARK;
        end else if (en) begin
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_deco_7seg.sv
// Directed bench for deco_7seg: three parameterisations share one stimulus
// and are compared against hand-computed segment values.
module tb_deco_7seg;

    logic       clk = 1'b0;
    logic       nreset;
    logic       en;
    logic [3:0] digit;
    logic       dp;
    logic       blank;
    logic       lamp_test;
    logic [7:0] seg_hex;
    logic [7:0] seg_nohex;
    logic [7:0] seg_pos;

    int total = 0;
    int bad   = 0;

    // Active-low codes for 0..F with dp off.
    logic [7:0] exp_al [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    // Active-high glyphs for 0..F with dp off.
    logic [7:0] exp_ah [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    always #5 clk = ~clk;

    deco_7seg #(.ACTIVE_LOW(1), .HEX_EN(1)) dut (
        .clk(clk), .nreset(nreset), .en(en), .digit(digit), .dp(dp),
        .blank(blank), .lamp_test(lamp_test), .seg(seg_hex)
    );

    deco_7seg #(.ACTIVE_LOW(1), .HEX_EN(0)) dut_nohex (
        .clk(clk), .nreset(nreset), .en(en), .digit(digit), .dp(dp),
        .blank(blank), .lamp_test(lamp_test), .seg(seg_nohex)
    );

    deco_7seg #(.ACTIVE_LOW(0), .HEX_EN(1)) dut_pos (
        .clk(clk), .nreset(nreset), .en(en), .digit(digit), .dp(dp),
        .blank(blank), .lamp_test(lamp_test), .seg(seg_pos)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it; inputs change here too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nreset    = 1'b0;
        en        = 1'b1;
        digit     = 4'd8;
        dp        = 1'b0;
        blank     = 1'b0;
        lamp_test = 1'b0;

        step();
        step();
        check("reset_al",    seg_hex,   8'hFF);
        check("reset_nohex", seg_nohex, 8'hFF);
        check("reset_pos",   seg_pos,   8'h00);

        nreset = 1'b1;
        step();
        check("first_load_al",  seg_hex, 8'h80);
        check("first_load_pos", seg_pos, 8'h7F);

        for (int i = 0; i < 16; i++) begin
            digit = 4'(i);
            step();
            check($sformatf("sweep_al_%0d", i),  seg_hex, exp_al[i]);
            check($sformatf("sweep_pos_%0d", i), seg_pos, exp_ah[i]);
            check($sformatf("sweep_nohex_%0d", i), seg_nohex,
                  (i < 10) ? exp_al[i] : 8'hBF);
        end

        digit = 4'd12;
        step();
        check("nohex_12", seg_nohex, 8'hBF);
        digit = 4'd9;
        step();
        check("nohex_9", seg_nohex, 8'h90);

        digit = 4'd3;
        dp    = 1'b1;
        step();
        check("dp_al",  seg_hex, 8'h30);
        check("dp_pos", seg_pos, 8'hCF);
        blank = 1'b1;
        step();
        check("blank_al",  seg_hex, 8'hFF);
        check("blank_pos", seg_pos, 8'h00);
        lamp_test = 1'b1;
        step();
        check("lamp_over_blank_al",  seg_hex, 8'h00);
        check("lamp_over_blank_pos", seg_pos, 8'hFF);

        lamp_test = 1'b0;
        blank     = 1'b0;
        dp        = 1'b0;
        digit     = 4'd5;
        step();
        check("hold_load", seg_hex, 8'h92);
        en        = 1'b0;
        digit     = 4'd1;
        lamp_test = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hold_%0d", i), seg_hex, 8'h92);
        end
        en = 1'b1;
        step();
        check("hold_release", seg_hex, 8'h00);

        lamp_test = 1'b0;
        digit     = 4'd0;
        step();
        check("pos_zero", seg_pos, 8'h3F);
        en     = 1'b0;
        nreset = 1'b0;
        step();
        check("reset_over_en_pos", seg_pos, 8'h00);
        check("reset_over_en_al",  seg_hex, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
